gpr_access_ctrl: RTL
====================

GPR_ACCESS_CTRL -- requirements
Module: gpr_access_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command FIFO entries (power of two, >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command FIFO not full.
REQ-006 cmd_write  input  1  1 = write command, 0 = read command.
REQ-007 cmd_addr_a / cmd_addr_b  input  5 each  read addresses.
REQ-008 cmd_addr_c  input  5  write address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  read response present.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_data_a / rsp_data_b  output  32 each  read data.
REQ-013 gpr_write_enable  output  1  drives the GPR write_enable port.
REQ-014 gpr_addrA / gpr_addrB / gpr_addrC  output  5 each  drive the GPR address ports.
REQ-015 gpr_data_in_C  output  32  drives the GPR write data port.
REQ-016 gpr_data_out_A / gpr_data_out_B  input  32 each  GPR read data, combinational from the addresses.

Function
REQ-017 GPR contract: write on rising clk when write_enable=1; reads are asynchronous; no special handling of register 0.
REQ-018 Command accepted when cmd_valid && cmd_ready; fields pushed into the FIFO in order.
REQ-019 cmd_ready = !fifo_full; push and pop in the same cycle leave occupancy unchanged.
REQ-020 FSM states: IDLE, ISSUE, RESP.
REQ-021 IDLE and FIFO non-empty: pop head, register it onto gpr_* outputs, go to ISSUE.
REQ-022 Write command: gpr_write_enable=1 for exactly the ISSUE cycle; the GPR writes at the end of that cycle. Next state IDLE; no response generated.
REQ-023 Read command: gpr_addrA/B held during ISSUE; at the end of ISSUE, capture gpr_data_out_A/B into rsp_data_a/b, set rsp_valid=1, go to RESP.
REQ-024 RESP: rsp_valid and rsp_data are held stable until rsp_ready=1; on the handshake edge, clear rsp_valid and go to IDLE.
REQ-025 gpr_write_enable=0 in every state other than ISSUE-with-write.
REQ-026 Strict in-order execution: a read queued behind a write to the same address returns the new data.
REQ-027 Latency: write accepted at edge N updates the GPR at edge N+2 when idle. Read accepted at edge N gives rsp_valid=1 after edge N+2.
REQ-028 Throughput: one write per 2 cycles; one read per 3 cycles when rsp_ready is held high.
REQ-029 A full FIFO while in RESP holds cmd_ready=0 with no loss; commands are never dropped or reordered.
REQ-030 Unused gpr_* fields retain their last values; only gpr_write_enable gates writes.

Reset
REQ-031 When rst=1, immediately: FIFO empty, state IDLE, cmd_ready=1, rsp_valid=0, rsp_data_a/b=0, gpr_write_enable=0, gpr_addr*=0, gpr_data_in_C=0.
REQ-032 Reset during ISSUE aborts the in-flight write or read without a GPR write; queued commands are discarded.
REQ-033 Normal operation resumes on the first rising edge after rst is deasserted.

Structure
REQ-034 Shared package gpr_pkg holds ADDR_W=5, DATA_W=32, the FSM state encoding and the command field widths (1+5+5+5+32 bits).
REQ-035 One sub-module, cmd_fifo: synchronous FIFO, DEPTH parameter, full/empty flags, pointer wrap-around, async active-high reset.
REQ-036 The top level contains the FSM, output registers and response registers.

Verification
REQ-037 Bench with a behavioural GPR model: write r5=0xAAAAAAAA, write r15=0xFFFEAAAA, read A=5 B=15 -> rsp 0xAAAAAAAA / 0xFFFEAAAA.
REQ-038 Write r7=0x12345678 immediately followed by read A=7 B=0 -> rsp_data_a=0x12345678 (ordering).
REQ-039 Hold rsp_ready=0 for 10 cycles with 6 reads queued -> rsp_valid and data stable; cmd_ready=0 after 4 buffered; all 6 responses correct and in order.
REQ-040 Assert rst during the ISSUE cycle of write r9=0xDEADBEEF -> r9 unchanged, all outputs at reset values, FIFO empty.
REQ-041 Back-to-back writes to r1..r31 over wrap-around of the FIFO pointers, then read them all back -> every value matches; gpr_write_enable pulse count = 31.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared types for the GPR access controller: widths,
// FSM encoding and the packed command record.
package gpr_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 1 + 3 * ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic cmd_t pack_cmd(
    input logic              write,
    input logic [ADDR_W-1:0] addr_a,
    input logic [ADDR_W-1:0] addr_b,
    input logic [ADDR_W-1:0] addr_c,
    input logic [DATA_W-1:0] wdata
  );
    cmd_t c;
    c.write  = write;
    c.addr_a = addr_a;
    c.addr_b = addr_b;
    c.addr_c = addr_c;
    c.wdata  = wdata;
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO. Ports: push/din/full on the
// write side, pop/dout/empty on the read side; async reset.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gpr_access_ctrl.sv
// Sequences queued read/write commands onto a GPR file.
// Ports: cmd_* in, rsp_* out, gpr_* to/from the register file.
module gpr_access_ctrl
  import gpr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_c,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              gpr_write_enable,
  output logic [ADDR_W-1:0] gpr_addrA,
  output logic [ADDR_W-1:0] gpr_addrB,
  output logic [ADDR_W-1:0] gpr_addrC,
  output logic [DATA_W-1:0] gpr_data_in_C,
  input  logic [DATA_W-1:0] gpr_data_out_A,
  input  logic [DATA_W-1:0] gpr_data_out_B
);

  state_t state;
  state_t state_n;
  cmd_t   in_cmd;
  cmd_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;

  assign in_cmd = pack_cmd(cmd_write, cmd_addr_a,
                           cmd_addr_b, cmd_addr_c,
                           cmd_wdata);
  assign cmd_ready = !fifo_full;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (in_cmd),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // In ISSUE the registered write enable tells us
  // whether the in-flight command is a write.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_n = gpr_write_enable ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Only the fields a command uses are reloaded; the
  // others keep their previous values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_write_enable <= 1'b0;
      gpr_addrA        <= '0;
      gpr_addrB        <= '0;
      gpr_addrC        <= '0;
      gpr_data_in_C    <= '0;
    end else begin
      gpr_write_enable <= 1'b0;
      if (pop) begin
        if (head.write) begin
          gpr_write_enable <= 1'b1;
          gpr_addrC        <= head.addr_c;
          gpr_data_in_C    <= head.wdata;
        end else begin
          gpr_addrA <= head.addr_a;
          gpr_addrB <= head.addr_b;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
    end else begin
      if (state == S_ISSUE && !gpr_write_enable) begin
        rsp_valid  <= 1'b1;
        rsp_data_a <= gpr_data_out_A;
        rsp_data_b <= gpr_data_out_B;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
